// File: rtl/decode_stage.sv
// RV32I/RV64I decode pipeline stage: one registered beat, valid/ready on both sides,
// with RV64 word ops, illegal-instruction flagging and a saturating illegal counter.
module decode_stage #(
  parameter int  XLEN     = 64,
  parameter bit  RV64     = 1'b1,
  parameter int  CNT_BITS = 16,
  localparam int ALU_TYPE_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [4:0]               out_rd,
  output logic [XLEN-1:0]          out_imm,
  output logic [ALU_TYPE_BITS-1:0] out_alu_op,
  output logic [2:0]               out_mem_mode,
  output logic                     out_mem_read,
  output logic                     out_mem_write,
  output logic                     out_reg_write,
  output logic                     out_is_word,
  output logic                     out_illegal,
  output logic [CNT_BITS-1:0]      illegal_cnt
);

  localparam logic [3:0] ALU_ADD     = 4'd0;
  localparam logic [3:0] ALU_SUB     = 4'd1;
  localparam logic [3:0] ALU_SHL     = 4'd2;
  localparam logic [3:0] ALU_SLT     = 4'd3;
  localparam logic [3:0] ALU_SLTU    = 4'd4;
  localparam logic [3:0] ALU_XOR     = 4'd5;
  localparam logic [3:0] ALU_SHR     = 4'd6;
  localparam logic [3:0] ALU_SHA     = 4'd7;
  localparam logic [3:0] ALU_OR      = 4'd8;
  localparam logic [3:0] ALU_AND     = 4'd9;
  localparam logic [3:0] ALU_SRC1    = 4'd10;
  localparam logic [3:0] ALU_INVALID = 4'd15;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [5:0]  w_funct6;
  logic [63:0] w_imm_i;
  logic [63:0] w_imm_s;
  logic [63:0] w_imm_b;
  logic [63:0] w_imm_u;
  logic [63:0] w_imm_j;
  logic [63:0] w_imm;
  logic [3:0]  w_alu_op;
  logic        w_illegal;
  logic        w_reg_write;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_is_word;
  logic        w_accept;

  logic                r_valid;
  logic [CNT_BITS-1:0] r_cnt;

  assign w_opcode = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];
  assign w_funct7 = in_instr[31:25];
  assign w_funct6 = in_instr[31:26];

  assign w_imm_i = {{52{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_b = {{51{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
  assign w_imm_u = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
  assign w_imm_j = {{43{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_alu_op    = ALU_INVALID;
    w_imm       = '0;
    w_illegal   = 1'b0;
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_is_word   = 1'b0;
    unique case (w_opcode)
      OPC_LUI: begin
        w_reg_write = 1'b1;
        w_alu_op    = ALU_SRC1;
        w_imm       = w_imm_u;
      end
      OPC_AUIPC: begin
        w_reg_write = 1'b1;
        w_alu_op    = ALU_ADD;
        w_imm       = w_imm_u;
      end
      OPC_JAL: begin
        w_reg_write = 1'b1;
        w_imm       = w_imm_j;
      end
      OPC_JALR: begin
        w_reg_write = 1'b1;
        w_imm       = w_imm_i;
      end
      OPC_BRANCH: begin
        w_imm = w_imm_b;
        unique case (w_funct3)
          3'b000, 3'b001: w_alu_op = ALU_SUB;
          3'b100, 3'b101: w_alu_op = ALU_SLT;
          3'b110, 3'b111: w_alu_op = ALU_SLTU;
          default:        w_illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        w_reg_write = 1'b1;
        w_mem_read  = 1'b1;
        w_alu_op    = ALU_ADD;
        w_imm       = w_imm_i;
        w_illegal   = RV64 ? (w_funct3 == 3'b111)
                           : (w_funct3 == 3'b011 || w_funct3 >= 3'b110);
      end
      OPC_STORE: begin
        w_mem_write = 1'b1;
        w_alu_op    = ALU_ADD;
        w_imm       = w_imm_s;
        w_illegal   = RV64 ? w_funct3[2] : (w_funct3 >= 3'b011);
      end
      OPC_OP_IMM: begin
        w_reg_write = 1'b1;
        w_imm       = w_imm_i;
        unique case (w_funct3)
          3'b000: w_alu_op = ALU_ADD;
          3'b010: w_alu_op = ALU_SLT;
          3'b011: w_alu_op = ALU_SLTU;
          3'b100: w_alu_op = ALU_XOR;
          3'b110: w_alu_op = ALU_OR;
          3'b111: w_alu_op = ALU_AND;
          default: begin
            // RV64 shifts carry a 6-bit shamt, so only funct6 is checked there
            w_imm    = RV64 ? {58'b0, in_instr[25:20]} : {59'b0, in_instr[24:20]};
            w_alu_op = (w_funct3 == 3'b001) ? ALU_SHL : (in_instr[30] ? ALU_SHA : ALU_SHR);
            if (RV64)
              w_illegal = !(w_funct6 == 6'b000000 ||
                            (w_funct3 == 3'b101 && w_funct6 == 6'b010000));
            else
              w_illegal = !(w_funct7 == 7'b0000000 ||
                            (w_funct3 == 3'b101 && w_funct7 == 7'b0100000));
          end
        endcase
      end
      OPC_OP: begin
        w_reg_write = 1'b1;
        unique case (w_funct3)
          3'b000: w_alu_op = in_instr[30] ? ALU_SUB : ALU_ADD;
          3'b001: w_alu_op = ALU_SHL;
          3'b010: w_alu_op = ALU_SLT;
          3'b011: w_alu_op = ALU_SLTU;
          3'b100: w_alu_op = ALU_XOR;
          3'b101: w_alu_op = in_instr[30] ? ALU_SHA : ALU_SHR;
          3'b110: w_alu_op = ALU_OR;
          default: w_alu_op = ALU_AND;
        endcase
        w_illegal = !(w_funct7 == 7'b0000000 ||
                      (w_funct7 == 7'b0100000 && (w_funct3 == 3'b000 || w_funct3 == 3'b101)));
      end
      OPC_OP_IMM32: begin
        w_reg_write = 1'b1;
        w_is_word   = 1'b1;
        w_imm       = w_imm_i;
        unique case (w_funct3)
          3'b000: w_alu_op = ALU_ADD;
          3'b001: begin
            w_alu_op  = ALU_SHL;
            w_imm     = {59'b0, in_instr[24:20]};
            w_illegal = (w_funct7 != 7'b0000000);
          end
          3'b101: begin
            w_alu_op  = in_instr[30] ? ALU_SHA : ALU_SHR;
            w_imm     = {59'b0, in_instr[24:20]};
            w_illegal = !(w_funct7 == 7'b0000000 || w_funct7 == 7'b0100000);
          end
          default: w_illegal = 1'b1;
        endcase
        if (!RV64) w_illegal = 1'b1;
      end
      OPC_OP32: begin
        w_reg_write = 1'b1;
        w_is_word   = 1'b1;
        unique case (w_funct3)
          3'b000: begin
            w_alu_op  = in_instr[30] ? ALU_SUB : ALU_ADD;
            w_illegal = !(w_funct7 == 7'b0000000 || w_funct7 == 7'b0100000);
          end
          3'b001: begin
            w_alu_op  = ALU_SHL;
            w_illegal = (w_funct7 != 7'b0000000);
          end
          3'b101: begin
            w_alu_op  = in_instr[30] ? ALU_SHA : ALU_SHR;
            w_illegal = !(w_funct7 == 7'b0000000 || w_funct7 == 7'b0100000);
          end
          default: w_illegal = 1'b1;
        endcase
        if (!RV64) w_illegal = 1'b1;
      end
      OPC_SYSTEM: begin
        w_alu_op = ALU_INVALID;
      end
      default: w_illegal = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) w_illegal = 1'b1;
    if (w_illegal) begin
      w_reg_write = 1'b0;
      w_mem_read  = 1'b0;
      w_mem_write = 1'b0;
      w_is_word   = 1'b0;
      w_alu_op    = ALU_INVALID;
    end
    if (in_instr[11:7] == 5'd0) w_reg_write = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (in_ready) begin
      r_valid <= w_accept;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept && !flush && w_illegal && !(&r_cnt)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_pc        <= '0;
      out_rs1       <= '0;
      out_rs2       <= '0;
      out_rd        <= '0;
      out_imm       <= '0;
      out_alu_op    <= ALU_INVALID;
      out_mem_mode  <= '0;
      out_mem_read  <= 1'b0;
      out_mem_write <= 1'b0;
      out_reg_write <= 1'b0;
      out_is_word   <= 1'b0;
      out_illegal   <= 1'b0;
    end else if (w_accept) begin
      out_pc        <= in_pc;
      out_rs1       <= in_instr[19:15];
      out_rs2       <= in_instr[24:20];
      out_rd        <= in_instr[11:7];
      out_imm       <= w_imm[XLEN-1:0];
      out_alu_op    <= w_alu_op;
      out_mem_mode  <= w_funct3;
      out_mem_read  <= w_mem_read;
      out_mem_write <= w_mem_write;
      out_reg_write <= w_reg_write;
      out_is_word   <= w_is_word;
      out_illegal   <= w_illegal;
    end
  end

  assign out_valid   = r_valid;
  assign illegal_cnt = r_cnt;

endmodule
